branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
- Lookup is combinational from PCF and produces BranchPredictedF / BranchPredictedTargetF for the next-PC selector in the IF stage.
- Update is sequential, driven by conditional branches resolved in EX.
- Two 32-bit performance counters record resolved branches and mispredictions.

Parameters:
- IDX_W, 6, index width; the buffer has 2^IDX_W entries.
- CNT_ALLOC, 2'b10, counter value written when a new entry is allocated (weakly taken).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- PCF  in  32  fetch-stage PC (lookup address).
- BranchPredictedF  out  1  predict taken for PCF.
- BranchPredictedTargetF  out  32  predicted target for PCF; 0 when BranchPredictedF=0.
- PCE  in  32  PC of the instruction in EX.
- BranchInstE  in  1  EX holds a conditional branch.
- BranchE  in  1  EX branch resolved taken.
- BranchTarget  in  32  resolved branch target from EX.
- BranchPredictedE  in  1  prediction that was made for the EX instruction, carried down the pipeline.
- StallE  in  1  EX stage stalled.
- FlushE  in  1  EX stage flushed (bubble).
- BranchCnt  out  32  number of resolved conditional branches.
- MispredCnt  out  32  number of mispredicted conditional branches.

Behaviour:
- Address fields: idx = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]. PC[1:0] are ignored.
- Per-entry storage: valid (1 bit), tag, target (32 bits), cnt (2 bits).
- Lookup is purely combinational with zero-cycle latency.
  - hitF = valid[idxF] & (tag[idxF] == tagF).
  - BranchPredictedF = hitF & cnt[idxF][1].
  - BranchPredictedTargetF = BranchPredictedF ? target[idxF] : 32'h0.
- Update strobe: upd = BranchInstE & ~StallE & ~FlushE. Every state change below happens on the rising clk edge when upd=1.
  - hitE = valid[idxE] & (tag[idxE] == tagE).
  - hitE and BranchE=1: cnt saturating increment (11 stays 11); target <= BranchTarget.
  - hitE and BranchE=0: cnt saturating decrement (00 stays 00); target unchanged; entry stays valid.
  - Miss and BranchE=1: allocate or overwrite the entry at idxE. valid<=1, tag<=tagE, target<=BranchTarget, cnt<=CNT_ALLOC.
  - Miss and BranchE=0: no change to the table.
- Same-index collision: when the F lookup and the E update address the same index in one cycle, the lookup returns the pre-update contents. There is no write-through bypass.
- Performance counters, on each upd:
  - BranchCnt increments by 1.
  - MispredCnt increments by 1 when BranchE != BranchPredictedE.
  - Both counters wrap modulo 2^32.
- Reset: while rst_n=0 (asynchronous assert, synchronous-edge release), all valid bits clear, all cnt <= 2'b01, and BranchCnt = MispredCnt = 0.
  - Consequence: BranchPredictedF=0 and BranchPredictedTargetF=0 for any PCF.
  - tag/target arrays need not be reset.
  - Reset asserted mid-update wins: no write from that cycle survives.
- Stalled or flushed EX: no table or counter change, even if BranchInstE=1. This prevents double-counting a stalled branch.
- JAL and JALR are never entered into the buffer. The upstream logic must not assert BranchInstE for them.

Decomposition:
- Shared package btb_pkg holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - function sat_update(cnt, taken) returning the next 2-bit counter value;
  - localparam TAG_W = 30 - IDX_W.
- One sub-module, btb_perf_counters, holds the two wrap-around 32-bit counters. Inputs: clk, rst_n, upd, mispred.
- Storage arrays and lookup/update logic stay in branch_target_buffer.

Test Plan:
- Reset, then PCF=0x0000_0040 -> BranchPredictedF=0, BranchPredictedTargetF=0, BranchCnt=0, MispredCnt=0.
- Allocate: upd with PCE=0x40, BranchE=1, BranchTarget=0x100, BranchPredictedE=0. Next cycle PCF=0x40 -> BranchPredictedF=1, target=0x100, MispredCnt=1, BranchCnt=1.
- Counter decay on entry 0x40:
  - first not-taken update: cnt 10->01, so BranchPredictedF=0 for PCF=0x40 while the entry stays valid;
  - three further not-taken updates leave cnt at 00;
  - two taken updates give 00->01->10, so BranchPredictedF=1 again.
- Aliasing with IDX_W=6: PCE=0x140 taken to 0x200 overwrites idx 16.
  - PCF=0x40 -> BranchPredictedF=0 (tag mismatch).
  - PCF=0x140 -> BranchPredictedF=1, target=0x200.
- Qualification:
  - BranchInstE=1 with StallE=1 for 3 cycles, then one cycle StallE=0 -> BranchCnt increments exactly once.
  - FlushE=1 with BranchInstE=1 -> no change to table or counters.
  - Same-cycle update and lookup of the same index -> the F outputs show the old value; the new value is visible next cycle.
- Async reset: assert rst_n=0 between clock edges after entries are populated -> BranchPredictedF drops to 0 immediately (no clock needed); counters read 0.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer.
//   - 2-bit direction counter encodings (SNT/WNT/WT/ST)
//   - sat_update(): next saturating counter value for a resolved branch
//   - default index width and the matching tag width
package btb_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int unsigned IDX_W_DFLT = 6;
  // PC[1:0] are never part of index or tag.
  localparam int unsigned TAG_W = 30 - IDX_W_DFLT;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == ST) ? ST : cnt + 2'd1;
    end else begin
      nxt = (cnt == SNT) ? SNT : cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_perf_counters.sv
// Wrap-around performance counters for resolved conditional branches.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   upd          one resolved conditional branch this cycle
//   mispred      that branch was mispredicted (qualified by upd)
//   branch_cnt   resolved-branch count (mod 2^32)
//   mispred_cnt  misprediction count (mod 2^32)
module btb_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd,
  input  logic        mispred,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispred) begin
        mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit direction counter per entry.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   PCF                      fetch PC; combinational lookup
//   BranchPredictedF         predict taken for PCF
//   BranchPredictedTargetF   predicted target (0 when not predicted)
//   PCE, BranchInstE, BranchE, BranchTarget, BranchPredictedE
//                            resolved conditional branch in EX
//   StallE, FlushE           EX qualification; no update while either is set
//   BranchCnt, MispredCnt    performance counters
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned IDX_W     = IDX_W_DFLT,
  parameter logic [1:0]  CNT_ALLOC = WT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        BranchPredictedF,
  output logic [31:0] BranchPredictedTargetF,
  input  logic [31:0] PCE,
  input  logic        BranchInstE,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  input  logic        BranchPredictedE,
  input  logic        StallE,
  input  logic        FlushE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  localparam int unsigned Entries = 2 ** IDX_W;
  localparam int unsigned TagW    = 30 - IDX_W;

  logic            valid_q  [Entries];
  logic [1:0]      cnt_q    [Entries];
  logic [TagW-1:0] tag_q    [Entries];
  logic [31:0]     target_q [Entries];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TagW-1:0]  tag_f, tag_e;
  logic             hit_f, hit_e, upd;

  // Byte-offset bits carry no information for a 4-byte aligned fetch.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];

  // Lookup reads the registered arrays, so a same-index update in this cycle
  // is not visible until the next one.
  assign hit_f                  = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign BranchPredictedF       = hit_f && cnt_q[idx_f][1];
  assign BranchPredictedTargetF = BranchPredictedF ? target_q[idx_f] : 32'h0;

  assign upd   = BranchInstE && !StallE && !FlushE;
  assign hit_e = valid_q[idx_e] && (tag_e == tag_q[idx_e]);

  // Valid and direction state: reset to "empty, weakly not-taken".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= WNT;
      end
    end else if (upd) begin
      if (hit_e) begin
        cnt_q[idx_e] <= sat_update(cnt_q[idx_e], BranchE);
      end else if (BranchE) begin
        valid_q[idx_e] <= 1'b1;
        cnt_q[idx_e]   <= CNT_ALLOC;
      end
    end
  end

  // Tag and target need no reset; valid gates their use. A taken branch
  // always writes both (on a hit the tag is rewritten with the same value).
  always_ff @(posedge clk) begin
    if (upd && BranchE && rst_n) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= BranchTarget;
    end
  end

  btb_perf_counters u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd         (upd),
    .mispred     (BranchE != BranchPredictedE),
    .branch_cnt  (BranchCnt),
    .mispred_cnt (MispredCnt)
  );

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned NENT  = 64;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCF;
  logic        BranchPredictedF;
  logic [31:0] BranchPredictedTargetF;
  logic [31:0] PCE;
  logic        BranchInstE;
  logic        BranchE;
  logic [31:0] BranchTarget;
  logic        BranchPredictedE;
  logic        StallE;
  logic        FlushE;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  branch_target_buffer #(
    .IDX_W     (IDX_W),
    .CNT_ALLOC (2'b10)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .PCF                    (PCF),
    .BranchPredictedF       (BranchPredictedF),
    .BranchPredictedTargetF (BranchPredictedTargetF),
    .PCE                    (PCE),
    .BranchInstE            (BranchInstE),
    .BranchE                (BranchE),
    .BranchTarget           (BranchTarget),
    .BranchPredictedE       (BranchPredictedE),
    .StallE                 (StallE),
    .FlushE                 (FlushE),
    .BranchCnt              (BranchCnt),
    .MispredCnt             (MispredCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a table of entries indexed by (pc / 4) mod NENT.
  bit          m_valid [NENT];
  int unsigned m_tag   [NENT];
  int unsigned m_tgt   [NENT];
  int          m_cnt   [NENT];
  int unsigned m_br;
  int unsigned m_mis;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % NENT;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * NENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic model_update();
    int unsigned i;
    if (BranchInstE && !StallE && !FlushE) begin
      m_br++;
      if (BranchE != BranchPredictedE) m_mis++;
      i = idx_of(PCE);
      if (m_hit(PCE)) begin
        if (BranchE) begin
          m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = BranchTarget;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (BranchE) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(PCE);
        m_tgt[i]   = BranchTarget;
        m_cnt[i]   = 2;
      end
    end
  endtask

  // Called at posedge+1 with inputs set; checks pre-edge outputs, then clocks.
  task automatic cycle();
    #3;
    check("predF", {31'd0, BranchPredictedF}, {31'd0, m_pred(PCF)});
    check("tgtF", BranchPredictedTargetF, m_pred(PCF) ? m_tgt[idx_of(PCF)] : 32'h0);
    check("brcnt", BranchCnt, m_br);
    check("miscnt", MispredCnt, m_mis);
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic upd(input logic [31:0] pce, input logic br, input logic [31:0] tgt,
                     input logic prede);
    PCE = pce; BranchE = br; BranchTarget = tgt; BranchPredictedE = prede;
    BranchInstE = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    cycle();
    BranchInstE = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
  endfunction

  task automatic random_run(input int n);
    for (int k = 0; k < n; k++) begin
      PCF          = rand_pc();
      PCE          = rand_pc();
      BranchInstE  = ($urandom_range(0, 3) != 0);
      BranchE      = $urandom_range(0, 1) != 0;
      BranchTarget = $urandom & 32'hffff_fffc;
      StallE       = ($urandom_range(0, 7) == 0);
      FlushE       = ($urandom_range(0, 7) == 0);
      BranchPredictedE = ($urandom_range(0, 3) != 0) ? m_pred(PCE) : ($urandom_range(0, 1) != 0);
      cycle();
    end
    BranchInstE = 1'b0; StallE = 1'b0; FlushE = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    PCF = 32'h40; PCE = 32'h0; BranchInstE = 1'b0; BranchE = 1'b0; BranchTarget = 32'h0;
    BranchPredictedE = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_pred", {31'd0, BranchPredictedF}, 32'd0);
    check("rst_tgt", BranchPredictedTargetF, 32'h0);
    check("rst_br", BranchCnt, 32'd0);
    check("rst_mis", MispredCnt, 32'd0);

    // Allocate 0x40 -> 0x100
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    check("alloc_pred", {31'd0, BranchPredictedF}, 32'd1);
    check("alloc_tgt", BranchPredictedTargetF, 32'h100);
    check("alloc_br", BranchCnt, 32'd1);
    check("alloc_mis", MispredCnt, 32'd1);

    // Decay 10 -> 01 -> 00 (saturates), then climb back to 10
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    check("decay1_pred", {31'd0, BranchPredictedF}, 32'd0);
    repeat (3) upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b1, 32'h104, 1'b0);
    check("climb1_pred", {31'd0, BranchPredictedF}, 32'd0);
    upd(32'h40, 1'b1, 32'h104, 1'b0);
    check("climb2_pred", {31'd0, BranchPredictedF}, 32'd1);
    check("climb2_tgt", BranchPredictedTargetF, 32'h104);
    check("decay_br", BranchCnt, 32'd7);
    check("decay_mis", MispredCnt, 32'd4);

    // Aliasing: 0x140 shares idx 16 with 0x40
    upd(32'h140, 1'b1, 32'h200, 1'b0);
    check("alias_old", {31'd0, BranchPredictedF}, 32'd0);
    PCF = 32'h140;
    #1;
    check("alias_new", {31'd0, BranchPredictedF}, 32'd1);
    check("alias_tgt", BranchPredictedTargetF, 32'h200);

    // Stall three cycles then release: exactly one update
    PCE = 32'h80; BranchE = 1'b1; BranchTarget = 32'h300; BranchPredictedE = 1'b0;
    BranchInstE = 1'b1; StallE = 1'b1;
    repeat (3) cycle();
    StallE = 1'b0;
    cycle();
    BranchInstE = 1'b0;
    check("stall_br", BranchCnt, 32'd9);
    PCF = 32'h80;
    #1;
    check("stall_pred", {31'd0, BranchPredictedF}, 32'd1);

    // Flush: nothing changes
    PCE = 32'hC0; BranchE = 1'b1; BranchTarget = 32'h400; BranchInstE = 1'b1; FlushE = 1'b1;
    cycle();
    BranchInstE = 1'b0; FlushE = 1'b0;
    check("flush_br", BranchCnt, 32'd9);
    PCF = 32'hC0;
    #1;
    check("flush_pred", {31'd0, BranchPredictedF}, 32'd0);

    // Same-index update and lookup: old value this cycle, new value next
    PCF = 32'h140; PCE = 32'h140; BranchE = 1'b0; BranchPredictedE = 1'b1; BranchInstE = 1'b1;
    #3;
    check("coll_old", {31'd0, BranchPredictedF}, 32'd1);
    cycle();
    BranchInstE = 1'b0;
    check("coll_new", {31'd0, BranchPredictedF}, 32'd0);

    random_run(400);

    // Populate 0x140, then assert reset between edges
    upd(32'h140, 1'b1, 32'h200, 1'b0);
    upd(32'h140, 1'b1, 32'h200, 1'b0);
    PCF = 32'h140;
    #1;
    check("pre_arst_pred", {31'd0, BranchPredictedF}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_pred", {31'd0, BranchPredictedF}, 32'd0);
    check("arst_tgt", BranchPredictedTargetF, 32'h0);
    check("arst_br", BranchCnt, 32'd0);
    check("arst_mis", MispredCnt, 32'd0);
    model_reset();
    // Update attempted while reset is held must not survive
    upd(32'h140, 1'b1, 32'h500, 1'b0);
    rst_n = 1'b1;
    #1;
    check("post_rst_pred", {31'd0, BranchPredictedF}, 32'd0);
    check("post_rst_br", BranchCnt, 32'd0);

    random_run(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
